md_unit: RTL and testbench

MD_UNIT -- requirements
Module: md_unit

---
 rtl/md_pkg.sv | 42 ++++
 rtl/md_divider.sv | 96 +++++++++
 rtl/md_unit.sv | 162 ++++++++++++++++
 tb/tb_md_unit.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared opcode, FSM-state and op-class definitions for the multiply/divide unit.
// Every file of the md_unit slice imports this package.
package md_pkg;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  function automatic logic is_acc(input logic [3:0] op);
    return (op >= OP_MADD) && (op <= OP_MSUBU);
  endfunction

  function automatic logic is_mul(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || is_acc(op);
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_signed(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

  function automatic logic is_sub(input logic [3:0] op);
    return (op == OP_MSUB) || (op == OP_MSUBU);
  endfunction

endpackage

// File: rtl/md_divider.sv
// Restoring radix-2 divider on operand magnitudes, one quotient bit per cycle.
// Sign fixup, divide-by-zero and MIN/-1 results are resolved on the output side.
module md_divider
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             signed_op,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_dividend;
  logic [CNT_W-1:0] r_cnt;
  logic             r_active;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_dvz;
  logic             r_ovf;

  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;

  assign w_a_mag = (signed_op && dividend[WIDTH-1]) ? (-dividend) : dividend;
  assign w_b_mag = (signed_op && divisor[WIDTH-1])  ? (-divisor)  : divisor;
  // Trial subtraction is one bit wider so the borrow shows up as the sign bit.
  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_dvs};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rem      <= '0;
      r_quo      <= '0;
      r_dvs      <= '0;
      r_dividend <= '0;
      r_cnt      <= '0;
      r_active   <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_dvz      <= 1'b0;
      r_ovf      <= 1'b0;
    end else if (load) begin
      r_rem      <= '0;
      r_quo      <= w_a_mag;
      r_dvs      <= w_b_mag;
      r_dividend <= dividend;
      r_cnt      <= CNT_W'(WIDTH);
      r_active   <= 1'b1;
      r_neg_q    <= signed_op && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
      r_neg_r    <= signed_op && dividend[WIDTH-1];
      r_dvz      <= (divisor == '0);
      r_ovf      <= signed_op && (dividend == MIN_VAL) && (divisor == '1);
    end else if (r_cnt != '0) begin
      if (!w_diff[WIDTH]) begin
        r_rem <= w_diff[WIDTH-1:0];
        r_quo <= {r_quo[WIDTH-2:0], 1'b1};
      end else begin
        r_rem <= w_shift[WIDTH-1:0];
        r_quo <= {r_quo[WIDTH-2:0], 1'b0};
      end
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign done = r_active && (r_cnt == '0);

  always_comb begin
    quotient  = r_quo;
    remainder = r_rem;
    if (r_dvz) begin
      quotient  = '1;
      remainder = r_dividend;
    end else if (r_ovf) begin
      quotient  = MIN_VAL;
      remainder = '0;
    end else begin
      quotient  = r_neg_q ? (-r_quo) : r_quo;
      remainder = r_neg_r ? (-r_rem) : r_rem;
    end
  end

endmodule

// File: rtl/md_unit.sv
// HI/LO multiply/divide unit: multi-cycle mul/madd/msub/div with stall handshake,
// cancel support and single-cycle mthi/mtlo.
module md_unit
  import md_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MULT_LAT = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             start,
  output logic             busy,
  output logic             start_ok
);

  localparam int CNT_W = $clog2(WIDTH + MULT_LAT + 1);

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               r_busy;
  logic [3:0]         r_op;
  logic [2*WIDTH-1:0] r_prod;
  logic [2*WIDTH-1:0] r_hilo;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_idle;
  logic               w_accept;
  logic               w_mt;
  logic               w_write;
  logic               w_div_load;
  logic               w_div_done;
  logic               w_ext_a;
  logic               w_ext_b;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_result;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;

  assign w_idle     = (r_state == ST_IDLE);
  assign start      = is_mul(op) || is_div(op);
  assign w_accept   = w_idle && !cancel && start;
  assign w_mt       = w_idle && !cancel && ((op == OP_MTHI) || (op == OP_MTLO));
  assign w_div_load = w_accept && is_div(op);

  // One behavioural product; signedness is just the extension bit.
  assign w_ext_a = is_signed(op) & a[WIDTH-1];
  assign w_ext_b = is_signed(op) & b[WIDTH-1];
  assign w_prod  = {{WIDTH{w_ext_a}}, a} * {{WIDTH{w_ext_b}}, b};

  md_divider #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .reset     (reset),
    .load      (w_div_load),
    .dividend  (a),
    .divisor   (b),
    .signed_op (is_signed(op)),
    .quotient  (w_quo),
    .remainder (w_rem),
    .done      (w_div_done)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = is_div(op) ? ST_DIV : ST_MUL;
          w_cnt_nxt   = is_div(op) ? CNT_W'(WIDTH - 1) : CNT_W'(MULT_LAT - 1);
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_MUL, ST_DIV: begin
        if (cancel) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == '0) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    w_result = r_prod;
    if (is_div(r_op)) begin
      w_result = {w_rem, w_quo};
    end else if (is_acc(r_op)) begin
      w_result = is_sub(r_op) ? (r_hilo - r_prod) : (r_hilo + r_prod);
    end else begin
      w_result = r_prod;
    end
  end

  // A cancel landing on the DONE cycle still suppresses the write.
  assign w_write = (r_state == ST_DONE) && !cancel && (!is_div(r_op) || w_div_done);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_op   <= OP_NONE;
      r_prod <= '0;
      r_hilo <= '0;
    end else if (w_accept) begin
      r_op   <= op;
      r_prod <= w_prod;
      r_hilo <= {r_hi, r_lo};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_write) begin
      r_hi <= w_result[2*WIDTH-1:WIDTH];
      r_lo <= w_result[WIDTH-1:0];
    end else if (w_mt) begin
      if (op == OP_MTHI) begin
        r_hi <= a;
      end else begin
        r_lo <= a;
      end
    end
  end

  assign hi       = r_hi;
  assign lo       = r_lo;
  assign busy     = r_busy;
  assign start_ok = !r_busy;

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: a 32-bit instance for directed vectors and
// cancel/reset corners, and a 16-bit/MULT_LAT=1 instance for random traffic.
module tb_md_unit;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        cancel;
  logic [3:0]  op32, op16;
  logic [31:0] a32, b32, hi32, lo32;
  logic [15:0] a16, b16, hi16, lo16;
  logic        start32, busy32, ok32, start16, busy16, ok16;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] sb_q[$];
  logic [63:0] mdl32, mdl16;

  always #5 clk = ~clk;

  md_unit #(.WIDTH(32), .MULT_LAT(5)) u_dut32 (
    .clk(clk), .reset(reset), .op(op32), .a(a32), .b(b32), .cancel(cancel),
    .hi(hi32), .lo(lo32), .start(start32), .busy(busy32), .start_ok(ok32)
  );

  md_unit #(.WIDTH(16), .MULT_LAT(1)) u_dut16 (
    .clk(clk), .reset(reset), .op(op16), .a(a16), .b(b16), .cancel(cancel),
    .hi(hi16), .lo(lo16), .start(start16), .busy(busy16), .start_ok(ok16)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference: native 64-bit arithmetic on sign/zero-extended operands.
  function automatic logic [63:0] model(input int w, input logic [3:0] opc,
                                        input logic [31:0] av, input logic [31:0] bv,
                                        input logic [63:0] hilo);
    logic [63:0] m, pm, res, prod, a64, b64;
    longint      sa, sb, q, r;
    logic        sg;
    m   = (w == 32) ? 64'h0000_0000_FFFF_FFFF : 64'h0000_0000_0000_FFFF;
    pm  = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    a64 = {32'h0, av} & m;
    b64 = {32'h0, bv} & m;
    sg  = (opc == 4'd1) || (opc == 4'd3) || (opc == 4'd7) || (opc == 4'd9);
    sa  = a64;
    sb  = b64;
    if (sg && av[w-1]) sa = sa | ~m;
    if (sg && bv[w-1]) sb = sb | ~m;
    res = hilo;
    case (opc)
      4'd1, 4'd2, 4'd7, 4'd8, 4'd9, 4'd10: begin
        prod = sa * sb;
        prod = prod & pm;
        if (opc == 4'd7 || opc == 4'd8)       res = (hilo + prod) & pm;
        else if (opc == 4'd9 || opc == 4'd10) res = (hilo - prod) & pm;
        else                                  res = prod;
      end
      4'd3, 4'd4: begin
        if (b64 == 64'h0) begin
          res = (a64 << w) | m;
        end else begin
          q   = sa / sb;
          r   = sa % sb;
          res = ((r & m) << w) | (q & m);
        end
      end
      4'd5: res = (hilo & m) | (a64 << w);
      4'd6: res = (hilo & (m << w)) | a64;
      default: res = hilo;
    endcase
    return res;
  endfunction

  function automatic int lat_of(input bit w16, input logic [3:0] opc);
    if (opc inside {4'd1, 4'd2, 4'd7, 4'd8, 4'd9, 4'd10}) return w16 ? 2 : 6;
    else if (opc inside {4'd3, 4'd4})                     return w16 ? 17 : 33;
    else                                                  return 0;
  endfunction

  function automatic logic [63:0] hilo_of(input bit w16);
    return w16 ? {32'h0, hi16, lo16} : {hi32, lo32};
  endfunction

  task automatic set_op(input bit w16, input logic [3:0] opc,
                        input logic [31:0] av, input logic [31:0] bv);
    if (w16) begin
      op16 = opc; a16 = av[15:0]; b16 = bv[15:0];
    end else begin
      op32 = opc; a32 = av; b32 = bv;
    end
  endtask

  // Issue one op, optionally hammer the unit with MTHI while it is busy.
  task automatic issue(input bit w16, input logic [3:0] opc, input logic [31:0] av,
                       input logic [31:0] bv, input bit intrude);
    logic [63:0] exp;
    int cnt;
    if (w16) begin
      exp = model(16, opc, av, bv, mdl16); mdl16 = exp;
    end else begin
      exp = model(32, opc, av, bv, mdl32); mdl32 = exp;
    end
    sb_q.push_back(exp);
    set_op(w16, opc, av, bv);
    tick();
    set_op(w16, OP_NONE, av, bv);
    cnt = 0;
    while ((w16 ? busy16 : busy32) && cnt < 100) begin
      cnt++;
      if (intrude) set_op(w16, OP_MTHI, ~av, bv);
      tick();
    end
    set_op(w16, OP_NONE, av, bv);
    check($sformatf("lat w16=%0d op=%0d", w16, opc), 64'(cnt), 64'(lat_of(w16, opc)));
    check($sformatf("hilo w16=%0d op=%0d", w16, opc), hilo_of(w16), sb_q.pop_front());
  endtask

  initial begin
    logic [3:0]  rop;
    logic [31:0] ra, rb;
    reset = 1'b1; cancel = 1'b0;
    op32 = 4'd0; a32 = 32'h0; b32 = 32'h0;
    op16 = 4'd0; a16 = 16'h0; b16 = 16'h0;
    mdl32 = 64'h0; mdl16 = 64'h0;
    repeat (3) tick();
    reset = 1'b0;
    check("reset_hilo32", {hi32, lo32}, 64'h0);
    check("reset_busy32", 64'(busy32), 64'h0);
    check("reset_ok32", 64'(ok32), 64'h1);
    check("reset_hilo16", {32'h0, hi16, lo16}, 64'h0);

    issue(1'b0, OP_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
    check("mult_vec", {hi32, lo32}, 64'hFFFF_FFFF_FFFF_FFFA);
    issue(1'b0, OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check("div_vec", {hi32, lo32}, 64'hFFFF_FFFF_FFFF_FFFD);
    issue(1'b0, OP_DIVU, 32'd7, 32'd0, 1'b0);
    check("divu_zero", {hi32, lo32}, 64'h0000_0007_FFFF_FFFF);
    issue(1'b0, OP_MTHI, 32'h1234_5678, 32'd0, 1'b0);
    issue(1'b0, OP_MTLO, 32'hFFFF_FFFF, 32'd0, 1'b0);
    issue(1'b0, OP_MADDU, 32'd2, 32'd3, 1'b1);
    check("maddu_vec", {hi32, lo32}, 64'h1234_5679_0000_0005);
    issue(1'b0, OP_MSUB, 32'd5, 32'hFFFF_FFFD, 1'b0);
    issue(1'b0, OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    check("multu_max", {hi32, lo32}, 64'hFFFF_FFFE_0000_0001);
    issue(1'b0, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check("div_min_m1", {hi32, lo32}, 64'h0000_0000_8000_0000);
    issue(1'b0, OP_DIV, 32'd100, 32'hFFFF_FFF9, 1'b1);
    issue(1'b0, OP_MSUBU, 32'h0001_0000, 32'h0001_0000, 1'b0);
    issue(1'b0, 4'd13, 32'hAAAA_AAAA, 32'd1, 1'b0);

    // Cancel in IDLE suppresses both single-cycle and multi-cycle codes.
    cancel = 1'b1;
    set_op(1'b0, OP_MTHI, 32'hDEAD_BEEF, 32'd0);
    #1 check("start_mthi", 64'(start32), 64'h0);
    tick();
    check("cancel_idle_mthi", {hi32, lo32}, mdl32);
    set_op(1'b0, OP_MULT, 32'd9, 32'd9);
    #1 check("start_mult", 64'(start32), 64'h1);
    tick();
    check("cancel_idle_busy", 64'(busy32), 64'h0);
    cancel = 1'b0;
    set_op(1'b0, OP_NONE, 32'd0, 32'd0);

    // Cancel at the third busy cycle, with an op offered while busy.
    set_op(1'b0, OP_MULT, 32'h11, 32'h22);
    tick();
    set_op(1'b0, OP_MTLO, 32'h5555, 32'd0);
    tick();
    tick();
    cancel = 1'b1;
    set_op(1'b0, OP_NONE, 32'd0, 32'd0);
    tick();
    cancel = 1'b0;
    check("cancel_busy", 64'(busy32), 64'h0);
    check("cancel_keep", {hi32, lo32}, mdl32);
    repeat (10) tick();
    check("cancel_no_late", {hi32, lo32}, mdl32);

    // Cancel coinciding with the DONE cycle.
    set_op(1'b0, OP_MULT, 32'h7, 32'h3);
    tick();
    set_op(1'b0, OP_NONE, 32'd0, 32'd0);
    repeat (5) tick();
    check("done_busy", 64'(busy32), 64'h1);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    check("cancel_done_busy", 64'(busy32), 64'h0);
    check("cancel_done_keep", {hi32, lo32}, mdl32);

    // Reset at busy cycle 10 of a divide.
    set_op(1'b0, OP_DIV, 32'd100, 32'd7);
    tick();
    set_op(1'b0, OP_NONE, 32'd0, 32'd0);
    repeat (9) tick();
    check("div_busy10", 64'(busy32), 64'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("reset_mid_hilo", {hi32, lo32}, 64'h0);
    check("reset_mid_busy", 64'(busy32), 64'h0);
    repeat (40) tick();
    check("reset_no_write", {hi32, lo32}, 64'h0);
    mdl32 = 64'h0;
    mdl16 = 64'h0;

    // Narrow instance, random traffic.
    for (int i = 0; i < 40; i++) begin
      rop = 4'($urandom_range(1, 11));
      ra  = $urandom;
      rb  = $urandom;
      if (i % 7 == 3) rb = 32'h0;
      if (i % 11 == 5) begin
        rop = OP_DIV; ra = 32'h8000; rb = 32'hFFFF;
      end
      issue(1'b1, rop, ra, rb, (i % 3) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
